// File: rtl/mc_ctrl_gen_if.sv
// Bus-side and PE-side handshake bundle for mc_ctrl_gen.
//   bus_valid/bus_tag/bus_type/bus_data : beat offered by the global data bus
//   bus_ready                           : beat consumed this cycle
//   pe_valid/pe_type/pe_data            : head entry of the PE-side queue
//   pe_ready                            : PE accepts the head entry
// master : the side that drives the bus beat and the PE ready (bus/PE model).
// slave  : the controller itself.
interface mc_ctrl_gen_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 6
) ();

  logic              bus_valid;
  logic [ID_W-1:0]   bus_tag;
  logic [1:0]        bus_type;
  logic [DATA_W-1:0] bus_data;
  logic              bus_ready;

  logic              pe_valid;
  logic [1:0]        pe_type;
  logic [DATA_W-1:0] pe_data;
  logic              pe_ready;

  modport master (
    output bus_valid, bus_tag, bus_type, bus_data, pe_ready,
    input  bus_ready, pe_valid, pe_type, pe_data
  );

  modport slave (
    input  bus_valid, bus_tag, bus_type, bus_data, pe_ready,
    output bus_ready, pe_valid, pe_type, pe_data
  );

endinterface

// File: rtl/mc_ctrl_gen.sv
// Multicast controller between the global data bus and one PE.
// Each bus beat's tag is compared with a programmed ID under a mask (all-ones
// tag = broadcast). Matching beats of type weight/ifmap/psum are queued in a
// small FIFO; matching type-3 beats are consumed and counted as drops.
// Non-matching beats are always consumed so a stalled PE never blocks the bus.
// Ports:
//   clk, rstn          : clock (rising edge), asynchronous active-low reset
//   cfg_we/id/mask     : load new ID and compare mask (mask bit 1 = compared)
//   bus (slave)        : bus beat in, PE head entry out
//   fifo_count         : queue occupancy
//   drop_cnt           : saturating count of matching type-3 beats
module mc_ctrl_gen #(
  parameter int unsigned    DATA_W   = 32,
  parameter int unsigned    ID_W     = 6,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [ID_W-1:0] RESET_ID = '0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_we,
  input  logic [ID_W-1:0]        cfg_id,
  input  logic [ID_W-1:0]        cfg_mask,
  mc_ctrl_gen_if.slave           bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [1:0]        typ;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ID_W-1:0]  id_q, mask_q;
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_q, drop_d;

  logic full, match, accept, push, pop, drop;

  // Match, handshake and next-state logic.
  always_comb begin
    full   = (count_q == FULL_CNT);
    match  = (&bus.bus_tag) | (((bus.bus_tag ^ id_q) & mask_q) == '0);
    // A full queue holds matching beats even if a pop happens this cycle.
    accept = bus.bus_valid & match & ~full;
    push   = accept & (bus.bus_type != 2'd3);
    drop   = accept & (bus.bus_type == 2'd3);
    pop    = (count_q != '0) & bus.pe_ready;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Configuration registers; a new value applies to beats in the next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q   <= RESET_ID;
      mask_q <= '1;
    end else if (cfg_we) begin
      id_q   <= cfg_id;
      mask_q <= cfg_mask;
    end
  end

  // Queue control and drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{typ: bus.bus_type, data: bus.bus_data};
    end
  end

  // Outputs come straight from registered state; no bus-to-PE bypass.
  always_comb begin
    bus.bus_ready = ~match | ~full;
    bus.pe_valid  = (count_q != '0);
    bus.pe_type   = mem_q[rd_ptr_q].typ;
    bus.pe_data   = mem_q[rd_ptr_q].data;
    fifo_count    = count_q;
    drop_cnt      = drop_q;
  end

endmodule

// File: tb/tb_mc_ctrl_gen.sv
// Directed bench for mc_ctrl_gen (DATA_W=32, ID_W=6, DEPTH=4, RESET_ID=0).
module tb_mc_ctrl_gen;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 6;
  localparam int unsigned DEPTH  = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cfg_we;
  logic [ID_W-1:0] cfg_id, cfg_mask;
  logic [2:0]      fifo_count;
  logic [7:0]      drop_cnt;

  int errors = 0;
  int checks = 0;

  mc_ctrl_gen_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus_if ();

  mc_ctrl_gen #(
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .DEPTH   (DEPTH),
    .RESET_ID(6'd0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_mask  (cfg_mask),
    .bus       (bus_if.slave),
    .fifo_count(fifo_count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [ID_W-1:0] tag, input logic [1:0] typ,
                      input logic [DATA_W-1:0] data);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_tag   = tag;
    bus_if.bus_type  = typ;
    bus_if.bus_data  = data;
  endtask

  task automatic cfg(input logic [ID_W-1:0] id, input logic [ID_W-1:0] mask);
    cfg_we   = 1'b1;
    cfg_id   = id;
    cfg_mask = mask;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    int exp_d;
    int b;
    logic acc;

    rstn             = 1'b0;
    cfg_we           = 1'b0;
    cfg_id           = '0;
    cfg_mask         = '0;
    bus_if.bus_valid = 1'b0;
    bus_if.bus_tag   = '0;
    bus_if.bus_type  = '0;
    bus_if.bus_data  = '0;
    bus_if.pe_ready  = 1'b0;
    #2;

    // Reset values.
    chk("rst_pe_valid", 64'(bus_if.pe_valid), 64'd0);
    chk("rst_pe_type", 64'(bus_if.pe_type), 64'd0);
    chk("rst_pe_data", 64'(bus_if.pe_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    beat(6'd0, 2'd0, 32'd0);
    #1;
    chk("rst_bus_ready", 64'(bus_if.bus_ready), 64'd1);
    bus_if.bus_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Unicast stream, one cycle latency.
    cfg(6'd30, 6'h3F);
    bus_if.pe_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      beat(6'd30, 2'd0, 32'(i));
      #1;
      chk("uni_bus_ready", 64'(bus_if.bus_ready), 64'd1);
      tick();
      chk("uni_pe_valid", 64'(bus_if.pe_valid), 64'd1);
      chk("uni_pe_data", 64'(bus_if.pe_data), 64'(i));
      chk("uni_pe_type", 64'(bus_if.pe_type), 64'd0);
    end
    bus_if.bus_valid = 1'b0;
    tick();
    chk("uni_drained", 64'(bus_if.pe_valid), 64'd0);
    chk("uni_drop", 64'(drop_cnt), 64'd0);

    // Traffic for another PE is consumed and ignored.
    for (int i = 0; i < 10; i++) begin
      beat(6'd40, 2'd1, 32'(100 + i));
      #1;
      chk("other_bus_ready", 64'(bus_if.bus_ready), 64'd1);
      tick();
      chk("other_pe_valid", 64'(bus_if.pe_valid), 64'd0);
      chk("other_count", 64'(fifo_count), 64'd0);
    end

    // Mask group: id 32, mask 0x38 compares bits [5:3] only.
    cfg(6'd32, 6'h38);
    beat(6'd33, 2'd1, 32'h33);
    tick();
    chk("grp33_valid", 64'(bus_if.pe_valid), 64'd1);
    chk("grp33_data", 64'(bus_if.pe_data), 64'h33);
    beat(6'd39, 2'd1, 32'h39);
    tick();
    chk("grp39_valid", 64'(bus_if.pe_valid), 64'd1);
    chk("grp39_data", 64'(bus_if.pe_data), 64'h39);
    beat(6'd24, 2'd1, 32'h24);
    tick();
    chk("grp24_discard", 64'(bus_if.pe_valid), 64'd0);
    chk("grp24_count", 64'(fifo_count), 64'd0);
    beat(6'd63, 2'd1, 32'h63);
    tick();
    chk("bcast_valid", 64'(bus_if.pe_valid), 64'd1);
    chk("bcast_data", 64'(bus_if.pe_data), 64'h63);
    bus_if.bus_valid = 1'b0;
    tick();
    chk("grp_drained", 64'(fifo_count), 64'd0);

    // Backpressure: fill with pe_ready low, then drain.
    bus_if.pe_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      beat(6'd32, 2'd1, 32'(i));
      #1;
      chk("fill_bus_ready", 64'(bus_if.bus_ready), 64'd1);
      tick();
      chk("fill_count", 64'(fifo_count), 64'(i));
    end
    beat(6'd32, 2'd1, 32'd5);
    #1;
    chk("full_stall", 64'(bus_if.bus_ready), 64'd0);
    tick();
    chk("full_hold_count", 64'(fifo_count), 64'd4);
    chk("full_hold_ready", 64'(bus_if.bus_ready), 64'd0);
    chk("full_head", 64'(bus_if.pe_data), 64'd1);
    bus_if.pe_ready = 1'b1;
    #1;
    chk("full_pop_cycle", 64'(bus_if.bus_ready), 64'd0);
    exp_d = 1;
    b     = 5;
    for (int c = 0; c < 20; c++) begin
      if (b <= 6) beat(6'd32, 2'd1, 32'(b));
      else bus_if.bus_valid = 1'b0;
      #1;
      if (bus_if.pe_valid && bus_if.pe_ready) begin
        chk("drain_order", 64'(bus_if.pe_data), 64'(exp_d));
        exp_d++;
      end
      acc = bus_if.bus_valid && bus_if.bus_ready;
      tick();
      if (acc) b++;
      if (exp_d == 7 && b == 7) break;
    end
    bus_if.bus_valid = 1'b0;
    chk("drain_total", 64'(exp_d), 64'd7);
    chk("drain_count", 64'(fifo_count), 64'd0);

    // Reserved type: counted, saturating, never queued.
    for (int i = 0; i < 260; i++) begin
      beat(6'd32, 2'd3, 32'(i));
      tick();
      if (i == 0) chk("drop_first", 64'(drop_cnt), 64'd1);
      if (i == 254) chk("drop_255", 64'(drop_cnt), 64'd255);
    end
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    chk("drop_count", 64'(fifo_count), 64'd0);
    chk("drop_pe_valid", 64'(bus_if.pe_valid), 64'd0);
    beat(6'd32, 2'd2, 32'd7);
    tick();
    chk("psum_valid", 64'(bus_if.pe_valid), 64'd1);
    chk("psum_type", 64'(bus_if.pe_type), 64'd2);
    chk("psum_data", 64'(bus_if.pe_data), 64'd7);
    bus_if.bus_valid = 1'b0;
    tick();

    // Asynchronous reset mid-stream.
    bus_if.pe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(6'd32, 2'd1, 32'(8'hA0 + i));
      tick();
    end
    bus_if.bus_valid = 1'b0;
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_pe_valid", 64'(bus_if.pe_valid), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    #1;
    rstn = 1'b1;
    tick();
    // id back to 0 with full mask: tag 32 no longer matches, tag 0 does.
    beat(6'd32, 2'd1, 32'h11);
    tick();
    chk("post_rst_old_id", 64'(fifo_count), 64'd0);
    beat(6'd0, 2'd1, 32'h55);
    #1;
    chk("post_rst_ready", 64'(bus_if.bus_ready), 64'd1);
    tick();
    bus_if.bus_valid = 1'b0;
    chk("post_rst_count", 64'(fifo_count), 64'd1);
    chk("post_rst_data", 64'(bus_if.pe_data), 64'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
